// File: rtl/lattice_result_collector.sv
// lattice_result_collector
//   Collects winning nonces from the tail of the lattice chain into a small
//   first-word-fall-through FIFO for the consumer, and tracks per-job status.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no job; results ignored
//   RUN   | job active; successes written to FIFO and counted
//   DRAIN | job ended; waiting for consumer to empty the FIFO
//   DONE  | job finished and drained; job_done pulses for this one cycle
//
// Ports
//   clk, rst                       clock, async active-high reset
//   job_start, job_end             one-cycle job control pulses
//   res_valid/success/partition/nonce   result from chain tail (no backpressure)
//   out_valid/ready/partition/nonce     FWFT result stream to consumer
//   overflow                       sticky: a success was dropped this job
//   hit_count                      saturating count of successes this job
//   job_done                       one-cycle pulse when job drained
//   busy                           high in RUN or DRAIN
module lattice_result_collector #(
  parameter int LOG2_NUM_CORES  = 1,
  parameter int LOG2_FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_start,
  input  logic                      job_end,
  input  logic                      res_valid,
  input  logic                      res_success,
  input  logic [LOG2_NUM_CORES-1:0] res_partition,
  input  logic [31:0]               res_nonce,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LOG2_NUM_CORES-1:0] out_partition,
  output logic [31:0]               out_nonce,
  output logic                      overflow,
  output logic [15:0]               hit_count,
  output logic                      job_done,
  output logic                      busy
);

  localparam int DEPTH = 2 ** LOG2_FIFO_DEPTH;
  localparam int EW    = LOG2_NUM_CORES + 32;

  localparam logic [LOG2_FIFO_DEPTH:0]   CNT_ONE  = 1;
  localparam logic [LOG2_FIFO_DEPTH:0]   CNT_FULL = DEPTH[LOG2_FIFO_DEPTH:0];
  localparam logic [LOG2_FIFO_DEPTH-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [EW-1:0]              mem [DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] wptr, rptr;
  logic [LOG2_FIFO_DEPTH:0]   count, count_nxt;
  logic                       full, pop, wr_req, wr_en;

  assign full      = (count == CNT_FULL);
  assign out_valid = (count != '0);
  assign {out_partition, out_nonce} = mem[rptr];

  // job_start flushes the FIFO, so neither a pop nor a write may happen
  // on that edge.
  assign pop    = out_valid & out_ready & ~job_start;
  assign wr_req = (state == RUN) & res_valid & res_success & ~job_start;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign wr_en  = wr_req & (~full | pop);

  always_comb begin
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // DRAIN leaves on the edge that empties the FIFO, so job_done lands the
  // cycle right after the last pop.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    job_done  = 1'b0;
    case (state)
      IDLE:  state_nxt = IDLE;
      RUN: begin
        busy = 1'b1;
        if (job_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (count_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        job_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (job_start) state_nxt = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      hit_count <= '0;
    end else if (job_start) begin
      state     <= state_nxt;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      hit_count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
      if (wr_req && !wr_en) overflow <= 1'b1;
      if (wr_req && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= {res_partition, res_nonce};
  end

endmodule

// File: tb/tb_lattice_result_collector.sv
module tb_lattice_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_start, job_end, res_valid, res_success;
  logic [0:0]  res_partition;
  logic [31:0] res_nonce;
  logic        out_valid, out_ready;
  logic [0:0]  out_partition;
  logic [31:0] out_nonce;
  logic        overflow;
  logic [15:0] hit_count;
  logic        job_done, busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;
  int p0;

  logic [32:0] sb[$];
  logic        pend = 1'b0;
  logic [32:0] pend_val;

  lattice_result_collector #(.LOG2_NUM_CORES(1), .LOG2_FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .job_start(job_start), .job_end(job_end),
    .res_valid(res_valid), .res_success(res_success),
    .res_partition(res_partition), .res_nonce(res_nonce),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_partition(out_partition), .out_nonce(out_nonce),
    .overflow(overflow), .hit_count(hit_count),
    .job_done(job_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; an accepted result becomes visible at this edge.
  task automatic cyc();
    @(posedge clk);
    if (pend) begin
      sb.push_back(pend_val);
      pend = 1'b0;
    end
    #1;
    job_start   = 1'b0;
    job_end     = 1'b0;
    res_valid   = 1'b0;
    res_success = 1'b0;
  endtask

  task automatic send(input logic part, input logic [31:0] nonce, input logic succ, input logic accept);
    res_valid     = 1'b1;
    res_success   = succ;
    res_partition = part;
    res_nonce     = nonce;
    if (accept) begin
      pend     = 1'b1;
      pend_val = {part, nonce};
    end
    cyc();
  endtask

  // Scoreboard: compare the head whenever the consumer takes it.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      if (out_valid && out_ready && !job_start && sb.size() > 0) begin
        check("head", {31'd0, out_partition, out_nonce}, {31'd0, sb.pop_front()});
        n_pops++;
      end
      if (job_start) sb.delete();
    end
  end

  initial begin
    rst = 1'b1; job_start = 0; job_end = 0; res_valid = 0; res_success = 0;
    res_partition = 0; res_nonce = 0; out_ready = 0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_job_done",  64'(job_done),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Three successes streamed straight out
    out_ready = 1; job_start = 1; cyc();
    check("run_busy", 64'(busy), 64'd1);
    send(1'b0, 32'h10, 1, 1);
    send(1'b1, 32'h20, 1, 1);
    send(1'b0, 32'h30, 1, 1);
    repeat (3) cyc();
    check("t1_pops", 64'(n_pops), 64'd3);
    check("t1_hit", 64'(hit_count), 64'd3);
    check("t1_ovf", 64'(overflow), 64'd0);

    // Overflow: six successes into four entries
    out_ready = 0; job_start = 1; cyc();
    for (int i = 0; i < 6; i++) send(i[0], 32'h100 + i, 1, i < 4);
    check("t2_ovf", 64'(overflow), 64'd1);
    check("t2_hit", 64'(hit_count), 64'd6);
    check("t2_count", 64'(dut.count), 64'd4);
    p0 = n_pops; out_ready = 1;
    repeat (6) cyc();
    check("t2_pops", 64'(n_pops - p0), 64'd4);

    // Full FIFO, pop and write on the same edge
    out_ready = 0; job_start = 1; cyc();
    check("t3_ovf_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) send(1'b1, 32'h200 + i, 1, 1);
    out_ready = 1;
    send(1'b0, 32'h2FF, 1, 1);
    out_ready = 0;
    check("t3_count", 64'(dut.count), 64'd4);
    check("t3_ovf", 64'(overflow), 64'd0);
    check("t3_hit", 64'(hit_count), 64'd5);
    out_ready = 1; repeat (5) cyc();

    // Drain after job_end with late consumer
    out_ready = 0; job_start = 1; cyc();
    send(1'b0, 32'h300, 1, 1);
    send(1'b1, 32'h301, 1, 1);
    job_end = 1; cyc();
    for (int i = 0; i < 2; i++) begin
      check("t4_busy_wait", 64'(busy), 64'd1);
      check("t4_done_wait", 64'(job_done), 64'd0);
      cyc();
    end
    out_ready = 1; cyc();
    check("t4_busy_1pop", 64'(busy), 64'd1);
    check("t4_done_1pop", 64'(job_done), 64'd0);
    cyc();
    check("t4_done_pulse", 64'(job_done), 64'd1);
    check("t4_busy_done", 64'(busy), 64'd0);
    cyc();
    check("t4_done_low", 64'(job_done), 64'd0);
    check("t4_idle_busy", 64'(busy), 64'd0);

    // Ignored results: IDLE, non-success, DRAIN
    out_ready = 0;
    send(1'b0, 32'h400, 1, 0);
    check("t5_idle_hit", 64'(hit_count), 64'd2);
    job_start = 1; cyc();
    send(1'b1, 32'h401, 0, 0);
    check("t5_nosucc_hit", 64'(hit_count), 64'd0);
    send(1'b1, 32'h402, 1, 1);
    check("t5_hit1", 64'(hit_count), 64'd1);
    job_end = 1; cyc();
    send(1'b0, 32'h403, 1, 0);
    check("t5_drain_hit", 64'(hit_count), 64'd1);
    check("t5_drain_count", 64'(dut.count), 64'd1);
    out_ready = 1;
    for (int i = 0; i < 10 && !job_done; i++) cyc();
    check("t5_done", 64'(job_done), 64'd1);

    // job_start while draining three entries
    cyc(); out_ready = 0; job_start = 1; cyc();
    for (int i = 0; i < 3; i++) send(1'b0, 32'h500 + i, 1, 1);
    job_end = 1; cyc();
    p0 = n_pops; out_ready = 1; job_start = 1; cyc();
    check("t6_count", 64'(dut.count), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_hit", 64'(hit_count), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    check("t6_busy", 64'(busy), 64'd1);
    check("t6_pops", 64'(n_pops - p0), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("t6_no_done", 64'(job_done), 64'd0);
      cyc();
    end

    // Reset mid-job discards entries and never finishes the job
    out_ready = 0;
    send(1'b1, 32'h600, 1, 1);
    send(1'b0, 32'h601, 1, 1);
    #2 rst = 1'b1;
    #1;
    check("t7_valid", 64'(out_valid), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_hit", 64'(hit_count), 64'd0);
    cyc(); rst = 1'b0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("t7_no_done", 64'(job_done), 64'd0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
